// File: rtl/seq_pkg.sv
// Shared state encoding for the serial pattern source and the run-of-ones detectors.
package seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b11
  } state_e;
endpackage

// File: rtl/register_r.sv
// Plain N-bit register with synchronous active-high clear.
module register_r #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end
endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: latches pattern/len/reps on start and shifts it
// out MSB-first, repeated back-to-back, then pulses done for one cycle.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [CW-1:0] reps,
  output logic          out,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d, idx_q, idx_d, len_in, sel_idx;
  logic [CW-1:0] rep_q, rep_d;
  logic [W-1:0]  sel_pat, shifted;
  logic          emit, out_d, busy_d, done_d;

  register_r #(.N(2)) u_state (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_q)
  );

  assign len_in = (len == '0 || len > LW'(W)) ? LW'(W) : len;

  // The bit for next cycle is selected here so out/out_valid can be flopped.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    sel_pat = pat_q;
    sel_idx = idx_q;
    emit    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_e'(state_q))
      S_IDLE: begin
        if (start) begin
          pat_d  = pattern;
          len_d  = len_in;
          rep_d  = reps;
          busy_d = 1'b1;
          if (reps == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SHIFT;
            idx_d   = len_in - LW'(1);
            sel_pat = pattern;
            sel_idx = len_in - LW'(1);
            emit    = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        if (idx_q == '0) begin
          if (rep_q == CW'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d   = rep_q - CW'(1);
            idx_d   = len_q - LW'(1);
            sel_idx = len_q - LW'(1);
            emit    = 1'b1;
          end
        end else begin
          idx_d   = idx_q - LW'(1);
          sel_idx = idx_q - LW'(1);
          emit    = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    shifted = sel_pat >> sel_idx;
    out_d   = emit & shifted[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      out       <= out_d;
      out_valid <= emit;
      busy      <= busy_d;
      done      <= done_d;
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: expected bits queued at start, popped as out_valid appears.
module tb_seq_pattern_tx;
  import seq_pkg::*;
  localparam int W = 8, LW = 4, CW = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [CW-1:0] reps;
  logic          out, out_valid, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(.W(W), .LW(LW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid bit must match the head of the queue.
  always @(negedge clk) begin
    bit e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("stray_bit", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("bit", {31'd0, out}, {31'd0, e});
      end
    end
  end

  task automatic run(input logic [W-1:0] pat, input logic [LW-1:0] l,
                     input logic [CW-1:0] r, input bit poke);
    int le, exp_done, n;
    bit seen;
    @(negedge clk);
    chk("idle_before", {31'd0, busy}, 32'd0);
    pattern = pat; len = l; reps = r; start = 1'b1;
    le = (l == 0 || int'(l) > W) ? W : int'(l);
    for (int rr = 0; rr < int'(r); rr++)
      for (int i = le - 1; i >= 0; i--) exp_q.push_back(pat[i]);
    exp_done = 1 + le * int'(r);
    @(posedge clk);
    #1 start = 1'b0; pattern = ~pat; len = 4'd2; reps = 4'd1;
    seen = 1'b0;
    for (n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (poke && n == 3) begin
        start = 1'b1; pattern = 8'hFF; len = 4'd1; reps = 4'd5;
      end else if (poke && n == 4) start = 1'b0;
      if (n == 1) chk("busy_rise", {31'd0, busy}, 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_cycle", seen ? n : 0, exp_done);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("valid_in_done", {31'd0, out_valid}, 32'd0);
    chk("bits_left", exp_q.size(), 32'd0);
    exp_q.delete();
    if (poke) begin
      start = 1'b1; pattern = 8'h0F; len = 4'd3; reps = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    bit any;
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out",   {31'd0, out},       32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    rst = 1'b0;

    run(8'b0011_0111, 4'd7,  4'd1, 1'b0);
    run(8'b0000_0101, 4'd3,  4'd3, 1'b0);
    run(8'hA5,        4'd0,  4'd1, 1'b0);
    run(8'hA5,        4'd12, 4'd1, 1'b0);
    run(8'hA5,        4'd8,  4'd0, 1'b0);
    run(8'b1100_1010, 4'd8,  4'd2, 1'b1);
    run(8'h3C,        4'd5,  4'd1, 1'b0);

    // Abort during bit 4 of an 8-bit send.
    @(negedge clk);
    pattern = 8'hB4; len = 4'd8; reps = 4'd1; start = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(pattern[i]);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_out",   {31'd0, out},       32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",  {31'd0, busy},      32'd0);
    chk("abort_done",  {31'd0, done},      32'd0);
    chk("abort_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
    chk("abort_bits_sent", exp_q.size(), 32'd3);
    exp_q.delete();
    #1 rst = 1'b0;
    any = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any |= done | busy;
    end
    chk("abort_no_done", {31'd0, any}, 32'd0);

    // Reset together with start: the request is lost.
    #1 rst = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd4; reps = 4'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any |= done | busy | out_valid;
    end
    chk("rst_start_lost", {31'd0, any}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Bit-serial pattern transmitter: latches a parallel pattern, then emits it one bit per clock, MSB first, repeated a programmable number of times. It is the source end of the serial bit stream consumed by the team's run-of-ones sequence detectors, and drives their `in` input in block-level benches and in the integrated datapath.

## Interface
Parameters:
- `W`, 8: maximum pattern width in bits.
- `LW`, 4: width of `len`; must satisfy 2^LW > W.
- `CW`, 4: width of `reps`.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high; the clock is `clk` and the reset is `rst`.
- `start`  in  1  request to begin a transmission; sampled only in IDLE.
- `pattern`  in  W  bits to send; `pattern[len-1]` is sent first.
- `len`  in  LW  number of pattern bits per repetition.
- `reps`  in  CW  number of repetitions.
- `out`  out  1  serial data bit; 0 whenever `out_valid`=0.
- `out_valid`  out  1  `out` carries a pattern bit this cycle.
- `busy`  out  1  high from the accept cycle +1 through the DONE cycle.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, DONE.
- In IDLE, `start`=1 is accepted. On the accept edge, latch `pattern`, `len` and `reps` into shadow registers. Inputs may change afterwards.
- Length rule: `len`=0 or `len`>W is clamped to W.
- Repetition rule: `reps`=0 means no bits are emitted; go IDLE→DONE directly.
- IDLE→SHIFT on accept when the effective reps ≥1.
- In SHIFT:
  - the bit index counts down from len-1 to 0, then reloads to len-1 and decrements the rep counter;
  - there are no gap cycles between repetitions;
  - SHIFT→DONE after bit 0 of the final repetition.
- DONE lasts exactly one cycle (`done`=1, `out_valid`=0), then returns to IDLE.
- `start` asserted while `busy` is ignored and not queued. `start` asserted in the DONE cycle is also ignored.
- All outputs are registered. `out` and `out_valid` come from flops, not from next-state logic.

## Timing
- Reset values: state IDLE, `out`=0, `out_valid`=0, `busy`=0, `done`=0, all counters and shadow registers 0.
- If start is accepted at edge t:
  - the first bit is valid in cycle t+1;
  - bit k (0-based) is valid in cycle t+1+k;
  - total valid cycles = len_eff × reps.
- `done` is high in cycle t+1+len_eff×reps. IDLE is reached the following cycle.
- For reps=0: `done` in cycle t+1, no valid cycles.
- `busy` = (state ≠ IDLE), registered, so it rises in cycle t+1.
- Back-to-back throughput: the earliest next accept is the IDLE cycle after DONE, i.e. one idle cycle between transmissions.
- Reset mid-operation: at the reset edge, abort immediately, all outputs return to reset values, and no `done` pulse is produced.
- Reset asserted together with `start`: reset wins and the start is lost.

## Structure
- Shared package `seq_pkg`:
  - state typedef, 2-bit: S_IDLE=2'b00, S_SHIFT=2'b01, S_DONE=2'b11;
  - the same encoding style as the detector FSMs, so benches can decode states uniformly.
- Sub-module: the state register is an instance of the codebase's `register_r` (synchronous-reset register, N=2). Next-state and output decode live in one combinational block with a default arm that returns to S_IDLE.
- Bit-index and rep counters are local sequential logic in this module.

## Test plan
- Reset, then pulse `start` with pattern=8'b0011_0111, len=7, reps=1 → `out` = 0,1,1,0,1,1,1 in cycles t+1..t+7 with `out_valid`=1; `done` at t+8. Fed into the Mealy detector, this yields 0,0,1,0,0,1,1.
- pattern=8'b0000_0101, len=3, reps=3 → 101101101 over 9 consecutive valid cycles with no gaps; `done` at t+10.
- len=0 and len=12, pattern=8'hA5, reps=1 → both send 8 bits 1,0,1,0,0,1,0,1; reps=0 → no valid cycles, `done` at t+1, `busy` high only in that cycle.
- `start` re-pulsed during SHIFT and during DONE with different inputs → ignored; the output stream and `done` timing are unchanged; an accept succeeds in the first IDLE cycle.
- `rst` asserted at bit 4 of an 8-bit send → next cycle all outputs are 0 and state is IDLE; no `done`. `rst` and `start` asserted together → no transmission.
